// File: rtl/harvos_mmu_pkg.sv
// Shared satp field layout, CSR operation/flush-state enums and the WARL
// legalization helper used by the satp CSR owner.
package harvos_mmu_pkg;

    // satp field layout for RV32 (MODE | ASID | PPN)
    localparam int SATP_MODE_BIT = 31;
    localparam int SATP_ASID_LSB = 22;
    localparam int SATP_ASID_W   = 9;
    localparam int SATP_PPN_W    = 22;

    // Privilege encodings as seen on priv_lvl
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        SATP_IDLE  = 1'b0,
        SATP_FLUSH = 1'b1
    } satp_flush_st_e;

    // MODE is hardwired to Sv32 and unimplemented ASID bits read as zero,
    // so any raw value maps onto exactly one legal satp value.
    function automatic logic [31:0] satp_legalize(input logic [31:0] raw, input int asid_w);
        logic [31:0] v;
        v = raw;
        v[SATP_MODE_BIT] = 1'b1;
        for (int i = 0; i < SATP_ASID_W; i++) begin
            if (i >= asid_w) begin
                v[SATP_ASID_LSB + i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/harvos_satp_csr.sv
// RV32 satp CSR owner: applies privileged CSR writes, keeps the value legal
// (always Sv32), and runs a TLB flush handshake after every effective change.
// CSR writes are back-pressured while a flush is outstanding.
module harvos_satp_csr
    import harvos_mmu_pkg::*;
#(
    parameter int              ASID_W    = 9,
    parameter logic [21:0]     RESET_PPN = 22'h0,
    parameter int              FLUSH_TMO = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  priv_lvl,
    input  logic        mstatus_tvm,
    output logic        csr_ready,
    output logic        csr_illegal,
    output logic [31:0] csr_rdata,
    output logic [31:0] csr_satp_q,
    output logic        tlb_flush_req,
    output logic        tlb_flush_all,
    output logic [8:0]  tlb_flush_asid,
    input  logic        tlb_flush_ack,
    output logic        flush_tmo_err
);

    // Timeout counter is at least 8 bits wide and saturates at all-ones
    localparam int CNT_W = ($clog2(FLUSH_TMO + 1) > 8) ? $clog2(FLUSH_TMO + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(FLUSH_TMO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0] SATP_RESET = {1'b1, 9'b0, RESET_PPN};

    satp_flush_st_e    state_reg, state_next;
    logic [31:0]       satp_reg, satp_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              all_reg, all_next;
    logic [8:0]        asid_reg, asid_next;
    logic              illegal_reg, illegal_next;
    logic              err_reg, err_next;
    logic              ready_comb;

    csr_op_e           op;
    logic              priv_ok;
    logic [31:0]       raw_val;
    logic [31:0]       legal_val;
    logic              mode_or_ppn_diff;

    assign op = csr_op_e'(csr_op);

    // U-mode never reaches satp; S-mode is trapped when TVM is set
    assign priv_ok = !((priv_lvl == PRIV_U) || ((priv_lvl == PRIV_S) && mstatus_tvm));

    // Candidate value from the CSR read-modify-write operation
    always_comb begin
        raw_val = satp_reg;
        case (op)
            CSR_OP_RW: raw_val = csr_wdata;
            CSR_OP_RS: raw_val = satp_reg | csr_wdata;
            CSR_OP_RC: raw_val = satp_reg & ~csr_wdata;
            default:   raw_val = satp_reg;
        endcase
    end

    assign legal_val = satp_legalize(raw_val, ASID_W);

    // A root-table or mode change invalidates everything; an ASID-only change
    // only needs the entries tagged with the outgoing ASID.
    assign mode_or_ppn_diff = (legal_val[SATP_PPN_W-1:0] != satp_reg[SATP_PPN_W-1:0]) ||
                              (legal_val[SATP_MODE_BIT] != satp_reg[SATP_MODE_BIT]);

    // Next-state and output logic for the write/flush handshake
    always_comb begin
        state_next   = state_reg;
        satp_next    = satp_reg;
        cnt_next     = cnt_reg;
        req_next     = req_reg;
        all_next     = all_reg;
        asid_next    = asid_reg;
        illegal_next = 1'b0;
        err_next     = err_reg;
        ready_comb   = 1'b0;

        case (state_reg)
            SATP_IDLE: begin
                ready_comb = 1'b1;
                if (csr_we) begin
                    if (!priv_ok) begin
                        illegal_next = 1'b1;
                    end else if ((op != CSR_OP_READ) && (legal_val != satp_reg)) begin
                        satp_next  = legal_val;
                        req_next   = 1'b1;
                        all_next   = mode_or_ppn_diff;
                        asid_next  = satp_reg[SATP_ASID_LSB +: SATP_ASID_W];
                        cnt_next   = '0;
                        state_next = SATP_FLUSH;
                    end
                end
            end

            SATP_FLUSH: begin
                if (tlb_flush_ack) begin
                    req_next   = 1'b0;
                    all_next   = 1'b0;
                    asid_next  = '0;
                    state_next = SATP_IDLE;
                end else if (cnt_reg == TMO_LAST) begin
                    // Give up on a TLB that never answers; leave a sticky flag
                    req_next   = 1'b0;
                    all_next   = 1'b0;
                    asid_next  = '0;
                    err_next   = 1'b1;
                    state_next = SATP_IDLE;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = SATP_IDLE;
            end
        endcase
    end

    // State and architectural register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= SATP_IDLE;
            satp_reg    <= SATP_RESET;
            cnt_reg     <= '0;
            req_reg     <= 1'b0;
            all_reg     <= 1'b0;
            asid_reg    <= '0;
            illegal_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            satp_reg    <= satp_next;
            cnt_reg     <= cnt_next;
            req_reg     <= req_next;
            all_reg     <= all_next;
            asid_reg    <= asid_next;
            illegal_reg <= illegal_next;
            err_reg     <= err_next;
        end
    end

    assign csr_ready      = ready_comb;
    assign csr_illegal    = illegal_reg;
    assign csr_satp_q     = satp_reg;
    assign csr_rdata      = satp_reg;
    assign tlb_flush_req  = req_reg;
    assign tlb_flush_all  = all_reg;
    assign tlb_flush_asid = asid_reg;
    assign flush_tmo_err  = err_reg;

endmodule

// File: tb/tb_harvos_satp_csr.sv
// Directed plus randomized bench for the satp CSR owner, checked against a
// value-level model of satp and the flush handshake.
module tb_harvos_satp_csr;

    localparam int          TMO   = 255;
    localparam logic [21:0] PPN4  = 22'h12345;
    localparam int          TMO4  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [31:0] csr_wdata = '0;
    logic [1:0]  priv_lvl = 2'b11;
    logic        mstatus_tvm = 1'b0;
    logic        tlb_flush_ack = 1'b0;
    logic        csr_ready, csr_illegal, tlb_flush_req, tlb_flush_all, flush_tmo_err;
    logic [31:0] csr_rdata, csr_satp_q;
    logic [8:0]  tlb_flush_asid;

    logic        b_we = 1'b0;
    logic        b_ack = 1'b0;
    logic        b_ready, b_illegal, b_req, b_all, b_err;
    logic [31:0] b_rdata, b_satp;
    logic [8:0]  b_asid;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [31:0] m_satp;
    logic        m_changed;
    logic        m_all;
    logic [8:0]  m_asid;

    always #5 clk = ~clk;

    harvos_satp_csr #(.ASID_W(9), .RESET_PPN(22'h0), .FLUSH_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .priv_lvl(priv_lvl), .mstatus_tvm(mstatus_tvm), .csr_ready(csr_ready),
        .csr_illegal(csr_illegal), .csr_rdata(csr_rdata), .csr_satp_q(csr_satp_q),
        .tlb_flush_req(tlb_flush_req), .tlb_flush_all(tlb_flush_all),
        .tlb_flush_asid(tlb_flush_asid), .tlb_flush_ack(tlb_flush_ack),
        .flush_tmo_err(flush_tmo_err)
    );

    harvos_satp_csr #(.ASID_W(4), .RESET_PPN(PPN4), .FLUSH_TMO(TMO4)) dut4 (
        .clk(clk), .rst(rst), .csr_we(b_we), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .priv_lvl(priv_lvl), .mstatus_tvm(mstatus_tvm), .csr_ready(b_ready),
        .csr_illegal(b_illegal), .csr_rdata(b_rdata), .csr_satp_q(b_satp),
        .tlb_flush_req(b_req), .tlb_flush_all(b_all),
        .tlb_flush_asid(b_asid), .tlb_flush_ack(b_ack),
        .flush_tmo_err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Legal satp: MODE forced to Sv32, ASID bits above aw read as zero
    function automatic logic [31:0] model_legal(input logic [31:0] raw, input int aw);
        logic [31:0] keep;
        keep = (32'd1 << (22 + aw)) - (32'd1 << 22);
        return (raw & ~(32'h7FC0_0000 & ~keep)) | 32'h8000_0000;
    endfunction

    // One CSR access to the main instance; leaves it in the cycle after acceptance
    task automatic csr_access(input logic [1:0] op, input logic [31:0] wd,
                              input logic [1:0] pl, input logic tvm);
        logic        ill;
        logic [31:0] raw, leg, old;
        old = m_satp;
        ill = (pl == 2'b00) || (pl == 2'b01 && tvm);
        case (op)
            2'b01:   raw = wd;
            2'b10:   raw = old | wd;
            2'b11:   raw = old & ~wd;
            default: raw = old;
        endcase
        leg = model_legal(raw, 9);
        m_changed = !ill && op != 2'b00 && leg != old;
        if (m_changed) begin
            m_satp = leg;
            m_all  = leg[21:0] != old[21:0];
            m_asid = old[30:22];
        end
        chk("ready_before_access", csr_ready, 1'b1);
        csr_we = 1'b1; csr_op = op; csr_wdata = wd; priv_lvl = pl; mstatus_tvm = tvm;
        tick();
        csr_we = 1'b0;
        $display("access op=%0d wdata=%h priv=%0d tvm=%0d -> satp=%h illegal=%0d req=%0d",
                 op, wd, pl, tvm, csr_satp_q, csr_illegal, tlb_flush_req);
        chk("illegal_pulse", csr_illegal, ill);
        chk("satp_value", csr_satp_q, m_satp);
        chk("rdata_value", csr_rdata, m_satp);
        chk("flush_req_raise", tlb_flush_req, m_changed);
        chk("mode_bit", csr_satp_q[31], 1'b1);
        if (m_changed) begin
            chk("flush_all", tlb_flush_all, m_all);
            chk("flush_asid", tlb_flush_asid, m_asid);
        end
    endtask

    // Hold off the ack for d cycles, then acknowledge and check the return to idle
    task automatic ack_after(input int d);
        for (int i = 0; i < d; i++) begin
            chk("flush_ready_low", csr_ready, 1'b0);
            chk("flush_req_held", tlb_flush_req, 1'b1);
            chk("flush_all_held", tlb_flush_all, m_all);
            chk("flush_asid_held", tlb_flush_asid, m_asid);
            tick();
        end
        tlb_flush_ack = 1'b1;
        tick();
        tlb_flush_ack = 1'b0;
        chk("ack_req_drop", tlb_flush_req, 1'b0);
        chk("ack_ready_high", csr_ready, 1'b1);
        chk("ack_illegal_quiet", csr_illegal, 1'b0);
        chk("ack_satp_stable", csr_satp_q, m_satp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] prv [3];
        prv[0] = 2'b00; prv[1] = 2'b01; prv[2] = 2'b11;

        // 1. Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_satp = 32'h8000_0000; m_all = 1'b0; m_asid = '0; m_changed = 1'b0;
        chk("reset_satp", csr_satp_q, 32'h8000_0000);
        chk("reset_ready", csr_ready, 1'b1);
        chk("reset_req", tlb_flush_req, 1'b0);
        chk("reset_all", tlb_flush_all, 1'b0);
        chk("reset_asid", tlb_flush_asid, 9'h0);
        chk("reset_illegal", csr_illegal, 1'b0);
        chk("reset_err", flush_tmo_err, 1'b0);
        chk("reset_satp_asidw4", b_satp, {1'b1, 9'b0, PPN4});

        // 2. Full flush after a root-table change
        csr_access(2'b01, 32'h0050_1234, 2'b11, 1'b0);
        chk("t2_satp", csr_satp_q, 32'h8050_1234);
        chk("t2_all", tlb_flush_all, 1'b1);
        ack_after(3);

        // 3. ASID-only change, then a write held pending across the ack
        csr_access(2'b10, 32'h0080_0000, 2'b11, 1'b0);
        chk("t3_all", tlb_flush_all, 1'b0);
        chk("t3_asid_old", tlb_flush_asid, 9'h001);
        csr_we = 1'b1; csr_op = 2'b01; csr_wdata = 32'h0000_0ABC; priv_lvl = 2'b11;
        tick();
        chk("t3_pending_ignored", csr_satp_q, m_satp);
        chk("t3_pending_ready", csr_ready, 1'b0);
        tlb_flush_ack = 1'b1;
        tick();
        tlb_flush_ack = 1'b0;
        chk("t3_ack_cycle_no_write", csr_satp_q, m_satp);
        chk("t3_ack_ready", csr_ready, 1'b1);
        chk("t3_ack_req", tlb_flush_req, 1'b0);
        tick();
        csr_we = 1'b0;
        m_asid = m_satp[30:22];
        m_all  = 1'b1;
        m_satp = 32'h8000_0ABC;
        $display("pending write accepted -> satp=%h req=%0d", csr_satp_q, tlb_flush_req);
        chk("t3_late_write", csr_satp_q, m_satp);
        chk("t3_late_req", tlb_flush_req, 1'b1);
        chk("t3_late_asid", tlb_flush_asid, m_asid);
        ack_after(0);

        // 4. Privilege checks
        csr_access(2'b01, 32'h1234_5678, 2'b01, 1'b1);
        tick();
        chk("t4_pulse_one_cycle", csr_illegal, 1'b0);
        csr_access(2'b00, 32'h0, 2'b00, 1'b0);
        tick();
        csr_access(2'b00, 32'h0, 2'b01, 1'b0);
        tick();

        // 5. Clear everything still leaves Sv32
        csr_access(2'b11, 32'hFFFF_FFFF, 2'b11, 1'b0);
        chk("t5_rc_all", csr_satp_q, 32'h8000_0000);
        ack_after(1);

        // 5b. Narrow ASID instance
        csr_op = 2'b01; csr_wdata = 32'h7FC0_0000; priv_lvl = 2'b11; mstatus_tvm = 1'b0;
        b_we = 1'b1;
        tick();
        b_we = 1'b0;
        $display("asid_w4 write -> satp=%h req=%0d", b_satp, b_req);
        chk("t5_w4_satp", b_satp, 32'h83C0_0000);
        chk("t5_w4_asid_field", b_satp[30:22], 9'h00F);
        chk("t5_w4_req", b_req, 1'b1);
        chk("t5_w4_all", b_all, 1'b1);
        chk("t5_w4_flush_asid", b_asid, 9'h000);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("t5_w4_ack", b_req, 1'b0);

        // Randomized accesses against the model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] wd;
            wd = $urandom;
            if ($urandom_range(0, 2) == 0) wd = wd & 32'h7FC0_0000;
            csr_access(2'($urandom_range(0, 3)), wd, prv[$urandom_range(0, 2)],
                       1'($urandom_range(0, 1)));
            if (m_changed) begin
                ack_after($urandom_range(0, 4));
            end else begin
                tick();
                chk("rand_pulse_end", csr_illegal, 1'b0);
            end
        end

        // 6. Flush timeout
        csr_access(2'b01, m_satp ^ 32'h0000_0001, 2'b11, 1'b0);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("t6_req_before_tmo", tlb_flush_req, 1'b1);
        chk("t6_err_before_tmo", flush_tmo_err, 1'b0);
        tick();
        $display("timeout -> req=%0d err=%0d ready=%0d", tlb_flush_req, flush_tmo_err, csr_ready);
        chk("t6_req_after_tmo", tlb_flush_req, 1'b0);
        chk("t6_err_set", flush_tmo_err, 1'b1);
        chk("t6_ready_after_tmo", csr_ready, 1'b1);
        csr_access(2'b01, m_satp ^ 32'h0000_0002, 2'b11, 1'b0);
        ack_after(2);
        chk("t6_err_sticky", flush_tmo_err, 1'b1);

        // 6b. Reset in the middle of a flush
        csr_access(2'b01, m_satp ^ 32'h0000_0004, 2'b11, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_satp = 32'h8000_0000;
        $display("reset mid-flush -> satp=%h req=%0d err=%0d", csr_satp_q, tlb_flush_req, flush_tmo_err);
        chk("t6_rst_req", tlb_flush_req, 1'b0);
        chk("t6_rst_satp", csr_satp_q, m_satp);
        chk("t6_rst_err", flush_tmo_err, 1'b0);
        chk("t6_rst_ready", csr_ready, 1'b1);
        tlb_flush_ack = 1'b1;
        tick();
        tlb_flush_ack = 1'b0;
        chk("t6_late_ack_req", tlb_flush_req, 1'b0);
        chk("t6_late_ack_satp", csr_satp_q, m_satp);
        chk("t6_late_ack_ready", csr_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
